// File: rtl/fetch_redirect_ctrl.sv
// rtl/fetch_redirect_ctrl.sv - fetch PC holder with taken-branch redirect and multi-cycle flush
module fetch_redirect_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 2,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             branch_signal,
  input  logic [31:0]      branch_target,
  input  logic             imem_ready,
  output logic [31:0]      pc,
  output logic             pc_valid,
  output logic             flush,
  output logic             misalign,
  output logic [CNT_W-1:0] redirect_cnt
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // Flush length is at most 7, so the remaining-cycle counter fits in 3 bits.
  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state, state_n;
  logic [2:0]       flush_cnt, flush_cnt_n;
  logic [31:0]      pc_n;
  logic             pc_valid_n;
  logic             flush_n;
  logic             misalign_n;
  logic [CNT_W-1:0] redirect_cnt_n;
  logic             accept;

  // A fetch is accepted only while a request is presented and nothing holds it back.
  assign accept = pc_valid & imem_ready & ~stall;

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= BOOT;
      flush_cnt    <= 3'd0;
      pc           <= RESET_PC;
      pc_valid     <= 1'b0;
      flush        <= 1'b0;
      misalign     <= 1'b0;
      redirect_cnt <= '0;
    end else begin
      state        <= state_n;
      flush_cnt    <= flush_cnt_n;
      pc           <= pc_n;
      pc_valid     <= pc_valid_n;
      flush        <= flush_n;
      misalign     <= misalign_n;
      redirect_cnt <= redirect_cnt_n;
    end
  end

  // Next-state and next-output logic; redirect wins over stall, stall over accept.
  always_comb begin
    state_n        = state;
    flush_cnt_n    = flush_cnt;
    pc_n           = pc;
    pc_valid_n     = pc_valid;
    flush_n        = flush;
    misalign_n     = 1'b0;
    redirect_cnt_n = redirect_cnt;

    unique case (state)
      BOOT: begin
        state_n    = RUN;
        pc_valid_n = 1'b1;
        flush_n    = 1'b0;
      end

      RUN: begin
        if (branch_signal) begin
          // The in-flight fetch is dropped; the target is force-aligned.
          pc_n        = {branch_target[31:2], 2'b00};
          pc_valid_n  = 1'b0;
          flush_n     = 1'b1;
          flush_cnt_n = FLUSH_LOAD;
          misalign_n  = |branch_target[1:0];
          if (redirect_cnt != '1) begin
            redirect_cnt_n = redirect_cnt + CNT_ONE;
          end
          state_n = FLUSH;
        end else if (accept) begin
          pc_n = pc + 32'd4;
        end
      end

      FLUSH: begin
        // Branches and memory readiness are ignored while squashing.
        if (flush_cnt == 3'd0) begin
          flush_n    = 1'b0;
          pc_valid_n = 1'b1;
          state_n    = RUN;
        end else begin
          flush_cnt_n = flush_cnt - 3'd1;
        end
      end

      default: begin
        state_n    = BOOT;
        pc_valid_n = 1'b0;
        flush_n    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb/tb_fetch_redirect_ctrl.sv - directed bench for fetch_redirect_ctrl
module tb_fetch_redirect_ctrl;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        branch_signal;
  logic [31:0] branch_target;
  logic        imem_ready;

  logic [31:0] a_pc;
  logic        a_pc_valid;
  logic        a_flush;
  logic        a_misalign;
  logic [15:0] a_redirect_cnt;

  logic [31:0] b_pc;
  logic        b_pc_valid;
  logic        b_flush;
  logic        b_misalign;
  logic [1:0]  b_redirect_cnt;

  int errors = 0;
  int checks = 0;

  fetch_redirect_ctrl u_a (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_signal (branch_signal),
    .branch_target (branch_target),
    .imem_ready    (imem_ready),
    .pc            (a_pc),
    .pc_valid      (a_pc_valid),
    .flush         (a_flush),
    .misalign      (a_misalign),
    .redirect_cnt  (a_redirect_cnt)
  );

  fetch_redirect_ctrl #(
    .RESET_PC     (32'hFFFF_FFFC),
    .FLUSH_CYCLES (3),
    .CNT_W        (2)
  ) u_b (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_signal (branch_signal),
    .branch_target (branch_target),
    .imem_ready    (imem_ready),
    .pc            (b_pc),
    .pc_valid      (b_pc_valid),
    .flush         (b_flush),
    .misalign      (b_misalign),
    .redirect_cnt  (b_redirect_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; branch_signal = 1'b0;
    branch_target = 32'h0; imem_ready = 1'b1;
    tick(); tick();
    chk("rst_pc",       a_pc, 32'h0);
    chk("rst_valid",    32'(a_pc_valid), 32'd0);
    chk("rst_flush",    32'(a_flush), 32'd0);
    chk("rst_misalign", 32'(a_misalign), 32'd0);
    chk("rst_cnt",      32'(a_redirect_cnt), 32'd0);
    chk("rst_b_pc",     b_pc, 32'hFFFF_FFFC);

    // Boot cycle, then sequential fetch; instance b wraps past the top of memory.
    rst_n = 1'b1;
    tick();
    chk("boot_valid",  32'(a_pc_valid), 32'd1);
    chk("boot_pc",     a_pc, 32'h0);
    chk("boot_b_pc",   b_pc, 32'hFFFF_FFFC);
    tick();
    chk("seq_pc4",     a_pc, 32'h4);
    chk("wrap_b_pc",   b_pc, 32'h0);
    tick(); chk("seq_pc8",  a_pc, 32'h8);
    tick(); chk("seq_pc12", a_pc, 32'hC);
    tick(); chk("seq_pc16", a_pc, 32'h10);

    // Stall holds the PC with the request still valid.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc",    a_pc, 32'h10);
      chk("stall_valid", 32'(a_pc_valid), 32'd1);
    end
    stall = 1'b0;
    tick(); chk("stall_resume", a_pc, 32'h14);

    // Memory not ready holds the PC the same way.
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("notready_pc", a_pc, 32'h14);
    end
    imem_ready = 1'b1;
    tick(); chk("ready_resume", a_pc, 32'h18);
    tick(); tick();
    chk("pre_branch_pc", a_pc, 32'h20);

    // Redirect to 0x200: two flush cycles in a, three in b.
    branch_signal = 1'b1; branch_target = 32'h200;
    tick();
    branch_signal = 1'b0;
    chk("br1_flush", 32'(a_flush), 32'd1);
    chk("br1_valid", 32'(a_pc_valid), 32'd0);
    chk("br1_pc",    a_pc, 32'h200);
    chk("br1_mis",   32'(a_misalign), 32'd0);
    chk("br1_cnt",   32'(a_redirect_cnt), 32'd1);
    chk("br1_b_flush", 32'(b_flush), 32'd1);
    tick();
    chk("br2_flush", 32'(a_flush), 32'd1);
    chk("br2_valid", 32'(a_pc_valid), 32'd0);
    chk("br2_pc",    a_pc, 32'h200);
    chk("br2_b_flush", 32'(b_flush), 32'd1);
    tick();
    chk("br3_flush", 32'(a_flush), 32'd0);
    chk("br3_valid", 32'(a_pc_valid), 32'd1);
    chk("br3_pc",    a_pc, 32'h200);
    chk("br3_b_flush", 32'(b_flush), 32'd1);
    tick();
    chk("br4_pc",    a_pc, 32'h204);
    chk("br4_b_flush", 32'(b_flush), 32'd0);
    chk("br4_b_valid", 32'(b_pc_valid), 32'd1);

    // A branch arriving during the flush is ignored.
    branch_signal = 1'b1; branch_target = 32'h300;
    tick();
    branch_target = 32'h400;
    tick();
    branch_signal = 1'b0;
    chk("ign_pc",    a_pc, 32'h300);
    chk("ign_flush", 32'(a_flush), 32'd1);
    tick();
    chk("ign_end_flush", 32'(a_flush), 32'd0);
    chk("ign_end_pc",    a_pc, 32'h300);
    chk("ign_cnt",       32'(a_redirect_cnt), 32'd2);

    // Redirect still taken with stall high and memory not ready.
    branch_signal = 1'b1; branch_target = 32'h500; stall = 1'b1; imem_ready = 1'b0;
    tick();
    branch_signal = 1'b0; stall = 1'b0; imem_ready = 1'b1;
    chk("stbr_pc",    a_pc, 32'h500);
    chk("stbr_flush", 32'(a_flush), 32'd1);
    tick(); tick();
    chk("stbr_valid", 32'(a_pc_valid), 32'd1);
    tick();
    chk("stbr_next",  a_pc, 32'h504);

    // Misaligned target is aligned and flagged for one cycle.
    branch_signal = 1'b1; branch_target = 32'h303;
    tick();
    branch_signal = 1'b0;
    chk("mis_pc",    a_pc, 32'h300);
    chk("mis_pulse", 32'(a_misalign), 32'd1);
    tick();
    chk("mis_clear", 32'(a_misalign), 32'd0);
    tick();
    chk("mis_valid", 32'(a_pc_valid), 32'd1);
    chk("mis_cnt",   32'(a_redirect_cnt), 32'd4);
    tick();
    chk("mis_next",  a_pc, 32'h304);

    // Reset in the first flush cycle.
    branch_signal = 1'b1; branch_target = 32'h600;
    tick();
    branch_signal = 1'b0;
    chk("pre_rst_flush", 32'(a_flush), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("mid_rst_flush", 32'(a_flush), 32'd0);
    chk("mid_rst_pc",    a_pc, 32'h0);
    chk("mid_rst_cnt",   32'(a_redirect_cnt), 32'd0);
    chk("mid_rst_valid", 32'(a_pc_valid), 32'd0);
    chk("mid_rst_b_pc",  b_pc, 32'hFFFF_FFFC);

    // Five redirects: the 2-bit counter sticks at 3, the 16-bit one reaches 5.
    rst_n = 1'b1;
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      branch_signal = 1'b1; branch_target = 32'h1000 + 32'(i) * 32'h100;
      tick();
      branch_signal = 1'b0;
      chk("sat_b_cnt", 32'(b_redirect_cnt), (i < 3) ? 32'(i + 1) : 32'd3);
      tick(); tick(); tick(); tick();
    end
    chk("sat_a_cnt", 32'(a_redirect_cnt), 32'd5);
    chk("sat_b_pc",  b_pc, 32'h1404);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
